// File: rtl/rgb_pwm_sequencer.sv
// RGB colour-wheel fader: a step tick walks a level through R->G->B->R phases and
// three PWM channels render the resulting duties with period-boundary shadowing.
module rgb_pwm_sequencer #(
  parameter int WIDTH      = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       EN,
  input  logic       TICK,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B,
  output logic [1:0] PHASE,
  output logic       WRAP
);

  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {
    S_RG = 2'd0,
    S_GB = 2'd1,
    S_BR = 2'd2
  } wheel_t;

  wheel_t           state;
  wheel_t           state_next;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_next;
  logic             wrap_next;
  logic [WIDTH-1:0] pwm_cnt;
  logic [WIDTH-1:0] dr;
  logic [WIDTH-1:0] dg;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] tr;
  logic [WIDTH-1:0] tg;
  logic [WIDTH-1:0] tb;
  logic             step;
  logic             boundary;

  assign step     = EN & TICK;
  assign boundary = EN && (pwm_cnt == MAX);
  assign PHASE    = state;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= S_RG;
      level <= '0;
      WRAP  <= 1'b0;
    end else begin
      state <= state_next;
      level <= level_next;
      WRAP  <= wrap_next;
    end
  end

  always_comb begin
    state_next = state;
    level_next = level;
    wrap_next  = 1'b0;
    tr         = '0;
    tg         = '0;
    tb         = '0;

    if (step) begin
      if (level == MAX) begin
        level_next = '0;
        case (state)
          S_RG: state_next = S_GB;
          S_GB: state_next = S_BR;
          S_BR: begin
            state_next = S_RG;
            wrap_next  = 1'b1;
          end
          default: state_next = S_RG;
        endcase
      end else begin
        level_next = level + WIDTH'(1);
      end
    end

    // Targets come from the current (pre-tick) registers, so a tick landing on a
    // period boundary only shows up one period later.
    case (state)
      S_RG: begin
        tr = MAX - level;
        tg = level;
      end
      S_GB: begin
        tg = MAX - level;
        tb = level;
      end
      S_BR: begin
        tb = MAX - level;
        tr = level;
      end
      default: begin
        tr = '0;
        tg = '0;
        tb = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pwm_cnt <= '0;
    end else if (EN) begin
      pwm_cnt <= pwm_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      dr <= '0;
      dg <= '0;
      db <= '0;
    end else if (boundary) begin
      dr <= tr;
      dg <= tg;
      db <= tb;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      LED_R <= ACTIVE_LOW;
      LED_G <= ACTIVE_LOW;
      LED_B <= ACTIVE_LOW;
    end else begin
      LED_R <= (EN && (pwm_cnt < dr)) ^ ACTIVE_LOW;
      LED_G <= (EN && (pwm_cnt < dg)) ^ ACTIVE_LOW;
      LED_B <= (EN && (pwm_cnt < db)) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer at WIDTH=4, running an active-high and an
// active-low instance side by side from the same stimulus.
module tb_rgb_pwm_sequencer;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       EN;
  logic       TICK;
  logic       led_r, led_g, led_b, wrap;
  logic       led_rn, led_gn, led_bn, wrap_n;
  logic [1:0] phase, phase_n;

  int checks = 0;
  int errors = 0;
  int acc_r, acc_g, acc_b, acc_rn, acc_gn, acc_bn, acc_n;
  int wrap_acc;

  always #5 CLK = ~CLK;

  rgb_pwm_sequencer #(.WIDTH(4), .ACTIVE_LOW(1'b0)) dut (
    .CLK(CLK), .RESETN(RESETN), .EN(EN), .TICK(TICK),
    .LED_R(led_r), .LED_G(led_g), .LED_B(led_b),
    .PHASE(phase), .WRAP(wrap)
  );

  rgb_pwm_sequencer #(.WIDTH(4), .ACTIVE_LOW(1'b1)) dut_n (
    .CLK(CLK), .RESETN(RESETN), .EN(EN), .TICK(TICK),
    .LED_R(led_rn), .LED_G(led_gn), .LED_B(led_bn),
    .PHASE(phase_n), .WRAP(wrap_n)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clear_acc();
    acc_r = 0; acc_g = 0; acc_b = 0;
    acc_rn = 0; acc_gn = 0; acc_bn = 0;
    acc_n = 0;
  endtask

  // One clock with TICK driven, then sample all outputs 1 time unit after the edge.
  task automatic apply_stimulus(input bit tick);
    TICK = tick;
    @(posedge CLK);
    #1;
    TICK = 1'b0;
    acc_n++;
    acc_r += int'(led_r);
    acc_g += int'(led_g);
    acc_b += int'(led_b);
    acc_rn += int'(led_rn);
    acc_gn += int'(led_gn);
    acc_bn += int'(led_bn);
    wrap_acc += int'(wrap);
  endtask

  task automatic check_window(input string tag, input int er, input int eg, input int eb);
    check_output({tag, ".r_high"}, acc_r, er);
    check_output({tag, ".g_high"}, acc_g, eg);
    check_output({tag, ".b_high"}, acc_b, eb);
    check_output({tag, ".r_high_inv"}, acc_rn, acc_n - er);
    check_output({tag, ".g_high_inv"}, acc_gn, acc_n - eg);
    check_output({tag, ".b_high_inv"}, acc_bn, acc_n - eb);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, ".led_r"}, led_r, 0);
    check_output({tag, ".led_g"}, led_g, 0);
    check_output({tag, ".led_b"}, led_b, 0);
    check_output({tag, ".led_r_inv"}, led_rn, 1);
    check_output({tag, ".led_g_inv"}, led_gn, 1);
    check_output({tag, ".led_b_inv"}, led_bn, 1);
    check_output({tag, ".phase"}, phase, 0);
    check_output({tag, ".wrap"}, wrap, 0);
    check_output({tag, ".phase_inv"}, phase_n, 0);
    check_output({tag, ".wrap_inv"}, wrap_n, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESETN = 1'b0;
    EN = 1'b0;
    TICK = 1'b0;
    wrap_acc = 0;
    clear_acc();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("por");

    RESETN = 1'b1;
    EN = 1'b1;

    // First period after release runs with zero duties.
    clear_acc();
    repeat (16) apply_stimulus(1'b0);
    check_window("first_dark", 0, 0, 0);

    // RG level 0 on screen; 8 separate tick pulses queue level 8.
    clear_acc();
    for (int i = 0; i < 16; i++) apply_stimulus(i % 2 == 0);
    check_window("rg_l0", 15, 0, 0);

    // RG level 8; a held TICK of 8 cycles crosses into GB.
    clear_acc();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(i < 8);
      if (i == 6) check_output("phase_rg_l15", phase, 0);
      if (i == 7) check_output("phase_to_gb", phase, 1);
    end
    check_window("rg_l8", 7, 8, 0);

    // GB level 0; 14 ticks then one tick exactly on the boundary cycle.
    clear_acc();
    for (int i = 0; i < 16; i++) apply_stimulus(i != 14);
    check_window("gb_l0", 0, 15, 0);
    check_output("phase_gb", phase, 1);

    // Boundary collision: this period shows level 14, not 15.
    clear_acc();
    repeat (16) apply_stimulus(1'b0);
    check_window("collide_pre", 0, 1, 14);

    // Collided tick visible one period later; one more tick enters BR.
    clear_acc();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(i == 0);
      if (i == 0) check_output("phase_to_br", phase, 2);
    end
    check_window("collide_post", 0, 0, 15);

    // BR level 0; 16 held ticks wrap back to RG.
    clear_acc();
    wrap_acc = 0;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1);
      if (i == 14) check_output("wrap_before", wrap, 0);
    end
    check_window("br_l0", 0, 0, 15);
    check_output("wrap_pulse", wrap, 1);
    check_output("phase_wrapped", phase, 0);

    // Enable gating: 4 ticks, then EN low at pwm_cnt=5 for 20 cycles.
    clear_acc();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(i < 4);
      if (i == 0) begin
        check_output("wrap_one_cycle", wrap, 0);
        check_output("wrap_count", wrap_acc, 1);
      end
    end
    check_window("gate_pre", 5, 0, 0);
    EN = 1'b0;
    clear_acc();
    for (int i = 0; i < 20; i++) apply_stimulus(i % 7 == 2);
    check_window("gate_off", 0, 0, 0);
    check_output("gate_phase", phase, 0);
    EN = 1'b1;
    clear_acc();
    repeat (11) apply_stimulus(1'b0);
    check_window("gate_resume", 10, 0, 0);

    // RG level 4 (disabled ticks ignored); 14 ticks reach GB level 2.
    clear_acc();
    for (int i = 0; i < 16; i++) apply_stimulus(i < 14);
    check_window("rg_l4", 11, 4, 0);
    check_output("phase_gb_again", phase, 1);

    // Partial GB level 2 period, then asynchronous reset mid-period.
    clear_acc();
    repeat (6) apply_stimulus(1'b0);
    check_window("gb_l2_part", 0, 6, 2);
    check_output("g_lit_before_reset", led_g, 1);
    #1;
    RESETN = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge CLK);
    #1;
    RESETN = 1'b1;

    clear_acc();
    repeat (16) apply_stimulus(1'b0);
    check_window("rerun_dark", 0, 0, 0);
    clear_acc();
    repeat (16) apply_stimulus(1'b0);
    check_window("rerun_rg_l0", 15, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
